mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   - FSM state encoding for the arbiter top
//   - line / beat widths
//   - requester identifiers (m0 = dcache, m1 = icache)
//   - done_match(): selects the done strobe matching the transaction direction
package mem_arb_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned BEAT_W = 32;

  localparam logic ID_DCACHE = 1'b0;
  localparam logic ID_ICACHE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  // A done strobe only counts when it matches the direction of the transaction.
  function automatic logic done_match(input logic is_wr, input logic rd_dn, input logic wr_dn);
    return is_wr ? wr_dn : rd_dn;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker.
// Ports:
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_req[1:0]      request levels (bit 0 = m0, bit 1 = m1)
//   i_update        commit the current pick (pointer moves only on a contested pick)
//   o_gnt_valid     at least one request present
//   o_gnt_id        winning requester
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  // Pointer names the requester that wins the next tie.
  logic r_ptr;

  always_comb begin
    o_gnt_valid = |i_req;
    if (&i_req) begin
      o_gnt_id = r_ptr;
    end else begin
      o_gnt_id = i_req[1];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= ID_DCACHE;
    end else if (i_update && (&i_req)) begin
      r_ptr <= ~o_gnt_id;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single backing-memory refill/writeback port between the dcache (m0)
// and the icache (m1). Round-robin grant, locked for a whole transaction and
// released on the memory's matching done pulse, followed by one RELEASE cycle.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   mX_req/wr/addr/wdata          requester transaction (level request)
//   mX_valid/data/rd_done/wr_done responses routed to the granted requester
//   req/wr/daddr/dirty_data       registered transaction towards memory
//   valid/data_i/rd_done/wr_done  memory responses
//   grant_id                      current/last owner
//   err                           watchdog timeout pulse
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the BUSY watchdog
// (TO_CYCLES cycles); otherwise err is tied low and BUSY waits indefinitely.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW        = 20,
  parameter int unsigned NUM       = 4,
  parameter int unsigned TO_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [AW-1:0]     m0_addr,
  input  logic [LINE_W-1:0] m0_wdata,
  output logic              m0_valid,
  output logic [BEAT_W-1:0] m0_data,
  output logic              m0_rd_done,
  output logic              m0_wr_done,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [AW-1:0]     m1_addr,
  input  logic [LINE_W-1:0] m1_wdata,
  output logic              m1_valid,
  output logic [BEAT_W-1:0] m1_data,
  output logic              m1_rd_done,
  output logic              m1_wr_done,
  output logic              req,
  output logic              wr,
  output logic [AW-1:0]     daddr,
  output logic [LINE_W-1:0] dirty_data,
  input  logic              valid,
  input  logic [BEAT_W-1:0] data_i,
  input  logic              rd_done,
  input  logic              wr_done,
  output logic              grant_id,
  output logic              err
);

  // Beat count is taken from rd_done; NUM only documents the line layout.
  if (NUM != 4) begin : g_num_check
    $error("mem_port_arbiter: NUM must be 4");
  end
  if (TO_CYCLES < 2) begin : g_to_check
    $error("mem_port_arbiter: TO_CYCLES must be at least 2");
  end

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic              r_req;
  logic              r_wr;
  logic [AW-1:0]     r_daddr;
  logic [LINE_W-1:0] r_dirty;
  logic              r_grant_id;

  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_grant_en;
  logic              w_busy;
  logic              w_done;
  logic              w_timeout;
  logic              w_release;

  rr_arb2 u_rr_arb2 (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_req       ({m1_req, m0_req}),
    .i_update    (w_grant_en),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  always_comb begin
    w_busy     = (r_state == ST_BUSY);
    w_grant_en = (r_state == ST_IDLE) && w_gnt_valid;
    w_done     = w_busy && done_match(r_wr, rd_done, wr_done);
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TO_CYCLES);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_grant_en) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_timeout = w_busy && !w_done && (r_cnt == CntW'(TO_CYCLES - 1));
  end
`else
  always_comb begin
    w_timeout = 1'b0;
  end
`endif

  always_comb begin
    w_release = w_done || w_timeout;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_gnt_valid) w_state_next = ST_BUSY;
      ST_BUSY:    if (w_release) w_state_next = ST_RELEASE;
      ST_RELEASE: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Memory-side transaction registers; operands stay put after release so
  // daddr/grant_id keep describing the last transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_wr       <= 1'b0;
      r_daddr    <= '0;
      r_dirty    <= '0;
      r_grant_id <= ID_DCACHE;
    end else if (w_grant_en) begin
      r_req      <= 1'b1;
      r_wr       <= w_gnt_id ? m1_wr : m0_wr;
      r_daddr    <= w_gnt_id ? m1_addr : m0_addr;
      r_dirty    <= w_gnt_id ? m1_wdata : m0_wdata;
      r_grant_id <= w_gnt_id;
    end else if (w_release) begin
      r_req <= 1'b0;
    end
  end

  // Outputs: response routing only while BUSY, so stray strobes are dropped.
  always_comb begin
    req        = r_req;
    wr         = r_wr;
    daddr      = r_daddr;
    dirty_data = r_dirty;
    grant_id   = r_grant_id;
    err        = w_timeout;
    m0_valid   = 1'b0;
    m0_data    = '0;
    m0_rd_done = 1'b0;
    m0_wr_done = 1'b0;
    m1_valid   = 1'b0;
    m1_data    = '0;
    m1_rd_done = 1'b0;
    m1_wr_done = 1'b0;
    if (w_busy) begin
      if (r_grant_id == ID_DCACHE) begin
        m0_valid   = valid;
        m0_data    = data_i;
        m0_rd_done = !r_wr && (rd_done || w_timeout);
        m0_wr_done = r_wr && (wr_done || w_timeout);
      end else begin
        m1_valid   = valid;
        m1_data    = data_i;
        m1_rd_done = !r_wr && (rd_done || w_timeout);
        m1_wr_done = r_wr && (wr_done || w_timeout);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic          id;
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [127:0]  data;
  } grant_t;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic id;
    logic is_wr;
  } done_t;

  logic clk = 1'b0;
  logic reset;
  logic m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [127:0] m0_wdata, m1_wdata;
  logic m0_valid, m0_rd_done, m0_wr_done, m1_valid, m1_rd_done, m1_wr_done;
  logic [31:0] m0_data, m1_data;
  logic req, wr, grant_id, err;
  logic [AW-1:0] daddr;
  logic [127:0] dirty_data;
  logic valid, rd_done, wr_done;
  logic [31:0] data_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW        (AW),
    .NUM       (4),
    .TO_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m0_wr      (m0_wr),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_valid   (m0_valid),
    .m0_data    (m0_data),
    .m0_rd_done (m0_rd_done),
    .m0_wr_done (m0_wr_done),
    .m1_req     (m1_req),
    .m1_wr      (m1_wr),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_valid   (m1_valid),
    .m1_data    (m1_data),
    .m1_rd_done (m1_rd_done),
    .m1_wr_done (m1_wr_done),
    .req        (req),
    .wr         (wr),
    .daddr      (daddr),
    .dirty_data (dirty_data),
    .valid      (valid),
    .data_i     (data_i),
    .rd_done    (rd_done),
    .wr_done    (wr_done),
    .grant_id   (grant_id),
    .err        (err)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard queues, filled by the stimulus side, drained by the monitor.
  grant_t grant_q[$];
  beat_t  beat_q[$];
  done_t  done_q[$];
  int     grant_log[$];

  // Reference model: port is either free, owned until a matching done, or in
  // a one-cycle cooldown after the done.
  bit          mon_en = 1'b1;
  bit          resp_en = 1'b1;
  logic        mdl_busy = 1'b0;
  logic        mdl_cool = 1'b0;
  logic        mdl_ptr = 1'b0;
  logic        mdl_owner = 1'b0;
  logic        mdl_wr = 1'b0;
  int unsigned mdl_txn = 0;
  grant_t      cur_g;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, req, 0);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_daddr"}, daddr, 0);
    chk({tag, "_dirty"}, dirty_data, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_m0_out"}, {m0_valid, m0_data, m0_rd_done, m0_wr_done}, 0);
    chk({tag, "_m1_out"}, {m1_valid, m1_data, m1_rd_done, m1_wr_done}, 0);
  endtask

  // Monitor + reference model.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      chk("req_level", req, mdl_busy);
      if (grant_q.size() > 0) begin
        cur_g = grant_q.pop_front();
        grant_log.push_back(int'(grant_id));
      end
      if (mdl_busy) begin
        chk("grant_id", grant_id, cur_g.id);
        chk("wr", wr, cur_g.is_wr);
        chk("daddr", daddr, cur_g.addr);
        chk("dirty_data", dirty_data, cur_g.data);
      end
      if (beat_q.size() > 0) begin
        beat_t b;
        b = beat_q.pop_front();
        chk("beat_route", {m1_valid, m0_valid}, b.id ? 2'b10 : 2'b01);
        chk("beat_data", b.id ? m1_data : m0_data, b.data);
      end else if (m0_valid || m1_valid) begin
        chk("stray_beat", {m1_valid, m0_valid}, 2'b00);
      end
      if (!(mdl_busy && mdl_owner == 1'b0)) chk("m0_data_idle", m0_data, 0);
      if (!(mdl_busy && mdl_owner == 1'b1)) chk("m1_data_idle", m1_data, 0);
      if (done_q.size() > 0) begin
        done_t d;
        d = done_q.pop_front();
        chk("done_route", {m1_wr_done, m1_rd_done, m0_wr_done, m0_rd_done},
            4'b0001 << {d.id, d.is_wr});
      end else if (m0_rd_done || m0_wr_done || m1_rd_done || m1_wr_done) begin
        chk("stray_done", {m1_wr_done, m1_rd_done, m0_wr_done, m0_rd_done}, 4'b0000);
      end
      chk("err_low", err, 0);

      // Model step for the coming clock edge.
      if (mdl_cool) begin
        mdl_cool = 1'b0;
      end else if (mdl_busy) begin
        if (mdl_wr ? wr_done : rd_done) begin
          mdl_busy = 1'b0;
          mdl_cool = 1'b1;
        end
      end else if (m0_req || m1_req) begin
        grant_t g;
        logic   w;
        w = (m0_req && m1_req) ? mdl_ptr : m1_req;
        if (m0_req && m1_req) mdl_ptr = ~w;
        g.id    = w;
        g.is_wr = w ? m1_wr : m0_wr;
        g.addr  = w ? m1_addr : m0_addr;
        g.data  = w ? m1_wdata : m0_wdata;
        grant_q.push_back(g);
        mdl_owner = w;
        mdl_wr    = g.is_wr;
        mdl_busy  = 1'b1;
        mdl_txn++;
      end
    end
  end

  // Memory responder.
  function automatic bit step_ok();
    return !reset;
  endfunction

  task automatic mem_step(output bit ok);
    @(posedge clk);
    #1;
    valid   = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    data_i  = $urandom;
    ok = step_ok();
  endtask

  task automatic serve(input logic id, input logic is_wr);
    bit ok;
    if (!is_wr) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 2) == 0) wr_done = 1'b1;  // wrong-direction done
          mem_step(ok);
          if (!ok) return;
        end
        valid  = 1'b1;
        data_i = $urandom;
        beat_q.push_back({id, data_i});
        mem_step(ok);
        if (!ok) return;
      end
      rd_done = 1'b1;
      done_q.push_back({id, 1'b0});
    end else begin
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 3) == 0) rd_done = 1'b1;  // wrong-direction done
        mem_step(ok);
        if (!ok) return;
      end
      wr_done = 1'b1;
      done_q.push_back({id, 1'b1});
    end
  endtask

  int unsigned served_txn = 0;
  initial begin
    valid   = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    data_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      valid   = 1'b0;
      rd_done = 1'b0;
      wr_done = 1'b0;
      data_i  = $urandom;
      if (!reset && resp_en && mdl_busy && mdl_txn != served_txn) begin
        served_txn = mdl_txn;
        serve(mdl_owner, mdl_wr);
      end else if (!reset && resp_en && !mdl_busy && $urandom_range(0, 5) == 0) begin
        // Noise while the port is not owned; must never reach a requester.
        case ($urandom_range(0, 2))
          0: valid = 1'b1;
          1: rd_done = 1'b1;
          default: wr_done = 1'b1;
        endcase
      end
    end
  end

  // Requester side.
  task automatic set_req(input bit id, input logic r);
    if (id == 1'b0) m0_req = r;
    else m1_req = r;
  endtask

  task automatic do_txn(input bit id, input logic is_wr, input logic [AW-1:0] a,
                        input logic [127:0] d, input bit keep, input bit drop_early);
    bit ok = 1'b0;
    bit dropped = 1'b0;
    @(posedge clk);
    #1;
    if (id == 1'b0) begin
      m0_req = 1'b1; m0_wr = is_wr; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = 1'b1; m1_wr = is_wr; m1_addr = a; m1_wdata = d;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (id == 1'b0 ? (m0_rd_done || m0_wr_done) : (m1_rd_done || m1_wr_done)) begin
        ok = 1'b1;
        break;
      end
      if (drop_early && !dropped && req && grant_id == id) begin
        // Dropping the request mid-transaction must not abort it.
        @(posedge clk);
        #1;
        set_req(id, 1'b0);
        dropped = 1'b1;
      end
    end
    chk(id ? "m1_done_seen" : "m0_done_seen", ok, 1);
    if (!keep) begin
      @(posedge clk);
      #1;
      set_req(id, 1'b0);
    end
  endtask

  task automatic rand_traffic(input bit id, input int n);
    bit keep = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!keep) repeat ($urandom_range(0, 4)) @(posedge clk);
      keep = ($urandom_range(0, 2) == 0);
      do_txn(id, logic'($urandom_range(0, 1)), AW'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, keep || (i == n - 1) ? keep : 1'b0,
             $urandom_range(0, 3) == 0);
    end
    @(posedge clk);
    #1;
    set_req(id, 1'b0);
  endtask

  int exp_order[4] = '{0, 1, 0, 1};

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Simultaneous requests after reset, both kept high: strict alternation.
    fork
      begin
        do_txn(1'b0, 1'b0, 20'h01230, '0, 1'b1, 1'b0);
        do_txn(1'b0, 1'b0, 20'h01270, '0, 1'b0, 1'b0);
      end
      begin
        do_txn(1'b1, 1'b1, 20'h00040, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b1, 1'b0);
        do_txn(1'b1, 1'b0, 20'h00080, '0, 1'b0, 1'b0);
      end
    join
    chk("fair_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      chk($sformatf("fair_order_%0d", i), grant_log[i], exp_order[i]);
    end

    // Randomised mixed traffic from both requesters.
    fork
      rand_traffic(1'b0, 25);
      rand_traffic(1'b1, 25);
    join
    repeat (4) @(posedge clk);

    // Reset on the second read beat.
    begin
      int  nb = 0;
      bit  hit = 1'b0;
      @(posedge clk);
      #1;
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 20'h01230;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (m0_valid) nb++;
        if (nb == 2) begin
          hit = 1'b1;
          break;
        end
      end
      chk("rst_second_beat_seen", hit, 1);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("mid_reset");
      @(posedge clk);
      #1;
      m0_req = 1'b0;
      mdl_busy = 1'b0; mdl_cool = 1'b0; mdl_ptr = 1'b0;
      grant_q.delete(); beat_q.delete(); done_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      do_txn(1'b1, 1'b0, 20'h00100, '0, 1'b0, 1'b0);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Silent memory: watchdog must release the port.
    begin
      bit found = 1'b0;
      repeat (3) @(posedge clk);
      mon_en = 1'b0;
      resp_en = 1'b0;
      @(posedge clk);
      #1;
      m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 20'h00200;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (req) begin
          found = 1'b1;
          break;
        end
      end
      chk("to_grant", found, 1);
      for (int k = 1; k <= TO; k++) begin
        chk($sformatf("to_err_c%0d", k), err, k == TO);
        chk($sformatf("to_done_c%0d", k), m0_rd_done, k == TO);
        if (k < TO) @(negedge clk);
      end
      @(posedge clk);
      #1;
      m0_req = 1'b0;
      @(negedge clk);
      chk("to_req_drop", req, 0);
      repeat (2) @(posedge clk);
      mdl_busy = 1'b0; mdl_cool = 1'b0;
      grant_q.delete(); beat_q.delete(); done_q.delete();
      mon_en = 1'b1;
      resp_en = 1'b1;
      do_txn(1'b0, 1'b1, 20'h00300, 128'hFEED, 1'b0, 1'b0);
    end
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("grant_q_empty", grant_q.size(), 0);
    chk("beat_q_empty", beat_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

endmodule
